// File: rtl/dark_subtract_engine_if.sv
// Request/response bus between the dark-subtract engine and the
// memory-manager stub. The engine takes the master side.
interface dark_subtract_engine_if;
   logic        ready_2_start;
   logic [31:0] user_rd_data;
   logic        rd_valid;
   logic        req;
   logic        rd_wr;
   logic [20:0] user_req_addr;
   logic [31:0] user_write_data;
   logic        set_done;
   logic        busy;
   logic [15:0] sat_count;

   modport master (
      input  ready_2_start, user_rd_data, rd_valid,
      output req, rd_wr, user_req_addr, user_write_data, set_done, busy, sat_count
   );

   modport slave (
      output ready_2_start, user_rd_data, rd_valid,
      input  req, rd_wr, user_req_addr, user_write_data, set_done, busy, sat_count
   );
endinterface

// File: rtl/dark_subtract_engine.sv
// Dark-frame subtraction engine. For every word of a set it reads the light
// word, reads the dark word and writes the per-pixel saturating difference
// (two 16-bit pixels per word), then pulses set_done.
// Optional macro DARK_SAT_COUNT_EN adds a counter of clamped pixels per set;
// without it sat_count is tied to zero.
module dark_subtract_engine #(
   parameter int          NUM_WORDS  = 1024,
   parameter logic [20:0] LIGHT_BASE = 21'h000000,
   parameter logic [20:0] DARK_BASE  = 21'h040000,
   parameter logic [20:0] OUT_BASE   = 21'h080000
) (
   input  logic                          clk,
   input  logic                          rst_n,
   dark_subtract_engine_if.master        bus
);

   typedef enum logic [2:0] {IDLE, RD_L, WT_L, RD_D, WT_D, WR, DONE} state_t;

   localparam logic [20:0] LAST_IDX = 21'(NUM_WORDS - 1);

   state_t      state_reg, state_next;
   logic [20:0] idx_reg, idx_next;
   logic [31:0] light_reg, light_next;
   logic        ready_q_reg;
   logic        req_reg, req_next;
   logic        rd_wr_reg, rd_wr_next;
   logic [20:0] addr_reg, addr_next;
   logic [31:0] wdata_reg, wdata_next;
   logic        set_done_reg, set_done_next;
   logic        busy_reg, busy_next;
   logic        start_edge;

   function automatic logic [15:0] sub16(input logic [15:0] a, input logic [15:0] b);
      return (a > b) ? (a - b) : 16'h0000;
   endfunction

   assign start_edge = bus.ready_2_start & ~ready_q_reg;

   // Next-state and registered-output decode; outputs follow the state entered.
   always_comb begin
      state_next    = state_reg;
      idx_next      = idx_reg;
      light_next    = light_reg;
      req_next      = 1'b0;
      rd_wr_next    = 1'b0;
      addr_next     = addr_reg;
      wdata_next    = wdata_reg;
      set_done_next = 1'b0;
      busy_next     = busy_reg;
      case (state_reg)
         IDLE: begin
            if (start_edge) begin
               state_next = RD_L;
               idx_next   = 21'd0;
               busy_next  = 1'b1;
               req_next   = 1'b1;
               addr_next  = LIGHT_BASE;
            end
         end
         RD_L: state_next = WT_L;
         WT_L: begin
            if (bus.rd_valid) begin
               light_next = bus.user_rd_data;
               state_next = RD_D;
               req_next   = 1'b1;
               addr_next  = DARK_BASE + idx_reg;
            end
         end
         RD_D: state_next = WT_D;
         WT_D: begin
            if (bus.rd_valid) begin
               state_next = WR;
               req_next   = 1'b1;
               rd_wr_next = 1'b1;
               addr_next  = OUT_BASE + idx_reg;
               wdata_next = {sub16(light_reg[31:16], bus.user_rd_data[31:16]),
                             sub16(light_reg[15:0],  bus.user_rd_data[15:0])};
            end
         end
         WR: begin
            if (idx_reg == LAST_IDX) begin
               state_next    = DONE;
               set_done_next = 1'b1;
            end else begin
               idx_next   = idx_reg + 21'd1;
               state_next = RD_L;
               req_next   = 1'b1;
               addr_next  = LIGHT_BASE + idx_reg + 21'd1;
            end
         end
         DONE: begin
            busy_next  = 1'b0;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // Losing the frame mid-set abandons it silently.
      if (state_reg != IDLE && state_reg != DONE && !bus.ready_2_start) begin
         state_next    = IDLE;
         busy_next     = 1'b0;
         req_next      = 1'b0;
         rd_wr_next    = 1'b0;
         set_done_next = 1'b0;
      end
   end

   // State and output registers. The edge detector resets high so that a
   // ready_2_start already high across reset cannot start a set.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         idx_reg      <= 21'd0;
         light_reg    <= 32'd0;
         ready_q_reg  <= 1'b1;
         req_reg      <= 1'b0;
         rd_wr_reg    <= 1'b0;
         addr_reg     <= 21'd0;
         wdata_reg    <= 32'd0;
         set_done_reg <= 1'b0;
         busy_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         idx_reg      <= idx_next;
         light_reg    <= light_next;
         ready_q_reg  <= bus.ready_2_start;
         req_reg      <= req_next;
         rd_wr_reg    <= rd_wr_next;
         addr_reg     <= addr_next;
         wdata_reg    <= wdata_next;
         set_done_reg <= set_done_next;
         busy_reg     <= busy_next;
      end
   end

   assign bus.req             = req_reg;
   assign bus.rd_wr           = rd_wr_reg;
   assign bus.user_req_addr   = addr_reg;
   assign bus.user_write_data = wdata_reg;
   assign bus.set_done        = set_done_reg;
   assign bus.busy            = busy_reg;

`ifdef DARK_SAT_COUNT_EN
   logic [31:0] dark_reg;
   logic [15:0] sat_reg;
   logic [1:0]  lanes;
   logic [16:0] sat_sum;

   assign lanes   = {1'b0, light_reg[31:16] <= dark_reg[31:16]} +
                    {1'b0, light_reg[15:0]  <= dark_reg[15:0]};
   assign sat_sum = {1'b0, sat_reg} + {15'd0, lanes};

   // Keep the dark word and count clamped lanes once per issued write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dark_reg <= 32'd0;
         sat_reg  <= 16'd0;
      end else begin
         if (state_reg == WT_D && bus.rd_valid)
            dark_reg <= bus.user_rd_data;
         if (state_reg == IDLE && start_edge)
            sat_reg <= 16'd0;
         else if (state_reg == WR)
            sat_reg <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
      end
   end

   assign bus.sat_count = sat_reg;
`else
   assign bus.sat_count = 16'h0000;
`endif

endmodule

// File: tb/tb_dark_subtract_engine.sv
// Bench for dark_subtract_engine: a memory responder with random read latency,
// a request log, and a word-level reference model of the subtraction.
module tb_dark_subtract_engine;
   localparam int NW = 4;
   localparam logic [20:0] LB = 21'h000000;
   localparam logic [20:0] DB = 21'h040000;
   localparam logic [20:0] OB = 21'h080000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dark_subtract_engine_if bus();

   dark_subtract_engine #(
      .NUM_WORDS(NW), .LIGHT_BASE(LB), .DARK_BASE(DB), .OUT_BASE(OB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] light_mem [NW];
   logic [31:0] dark_mem  [NW];
   int lat_min = 1;
   int lat_max = 1;

   logic [20:0] log_addr [$];
   logic        log_wr   [$];
   logic [31:0] log_data [$];
   int          done_cnt = 0;

   int          wait_cnt = 0;
   logic [31:0] pend_data;

   function automatic logic [31:0] mem_lookup(input logic [20:0] a);
      if (a >= LB && a < LB + NW) return light_mem[a - LB];
      if (a >= DB && a < DB + NW) return dark_mem[a - DB];
      return 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] model_word(input logic [31:0] l, input logic [31:0] d);
      int ah, bh, al, bl, rh, rl;
      ah = int'(l[31:16]); bh = int'(d[31:16]);
      al = int'(l[15:0]);  bl = int'(d[15:0]);
      rh = (ah > bh) ? ah - bh : 0;
      rl = (al > bl) ? al - bl : 0;
      return {rh[15:0], rl[15:0]};
   endfunction

   function automatic logic [15:0] model_sat();
      int s = 0;
      for (int i = 0; i < NW; i++) begin
         if (light_mem[i][31:16] <= dark_mem[i][31:16]) s++;
         if (light_mem[i][15:0]  <= dark_mem[i][15:0])  s++;
      end
      if (s > 65535) s = 65535;
      return s[15:0];
   endfunction

   // Memory side of the stub: log requests, answer reads after a random delay.
   always @(negedge clk) begin
      bus.rd_valid = 1'b0;
      if (wait_cnt > 0) begin
         wait_cnt--;
         if (wait_cnt == 0) begin
            bus.rd_valid     = 1'b1;
            bus.user_rd_data = pend_data;
         end
      end
      if (bus.req === 1'b1) begin
         log_addr.push_back(bus.user_req_addr);
         log_wr.push_back(bus.rd_wr);
         log_data.push_back(bus.user_write_data);
         if (bus.rd_wr === 1'b0) begin
            pend_data = mem_lookup(bus.user_req_addr);
            wait_cnt  = $urandom_range(lat_max, lat_min);
         end
      end
      if (bus.set_done === 1'b1) done_cnt++;
   end

   task automatic fill_random();
      for (int i = 0; i < NW; i++) begin
         light_mem[i] = $urandom;
         dark_mem[i]  = $urandom;
      end
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_wr.delete();
      log_data.delete();
      done_cnt = 0;
   endtask

   task automatic start_set(input int lmin, input int lmax);
      lat_min = lmin;
      lat_max = lmax;
      bus.ready_2_start = 1'b0;
      repeat (25) @(negedge clk);
      #1;
      clear_log();
      bus.ready_2_start = 1'b1;
   endtask

   task automatic run_set(input string name, input int lmin, input int lmax);
      int cyc = 0;
      start_set(lmin, lmax);
      while (done_cnt == 0 && cyc < 3000) begin
         @(negedge clk); #1;
         cyc++;
      end
      @(negedge clk); #1;
      n_checks++;
      if (done_cnt != 1) begin
         n_fail++;
         $display("FAIL %s done_count: got %0d expected 1", name, done_cnt);
      end
   endtask

   task automatic check_set(input string name);
      logic [15:0] exp_sat;
      n_checks++;
      if (log_addr.size() != 3 * NW) begin
         n_fail++;
         $display("FAIL %s req_count: got %0d expected %0d", name, log_addr.size(), 3 * NW);
      end else begin
         for (int i = 0; i < NW; i++) begin
            logic [20:0] ea [3];
            ea[0] = LB + 21'(i); ea[1] = DB + 21'(i); ea[2] = OB + 21'(i);
            for (int k = 0; k < 3; k++) begin
               n_checks++;
               if (log_addr[3*i+k] !== ea[k] || log_wr[3*i+k] !== (k == 2)) begin
                  n_fail++;
                  $display("FAIL %s req[%0d]: got addr %h wr %b expected addr %h wr %b",
                           name, 3*i+k, log_addr[3*i+k], log_wr[3*i+k], ea[k], k == 2);
               end
            end
            n_checks++;
            if (log_data[3*i+2] !== model_word(light_mem[i], dark_mem[i])) begin
               n_fail++;
               $display("FAIL %s wdata[%0d]: got %h expected %h", name, i,
                        log_data[3*i+2], model_word(light_mem[i], dark_mem[i]));
            end
         end
      end
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s busy_after_done: got %b expected 0", name, bus.busy);
      end
`ifdef DARK_SAT_COUNT_EN
      exp_sat = model_sat();
`else
      exp_sat = 16'h0000;
`endif
      n_checks++;
      if (bus.sat_count !== exp_sat) begin
         n_fail++;
         $display("FAIL %s sat_count: got %h expected %h", name, bus.sat_count, exp_sat);
      end
      $display("%s: set of %0d words, %0d requests, done=%0d", name, NW, log_addr.size(), done_cnt);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.ready_2_start = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus.req, bus.rd_wr, bus.user_req_addr, bus.user_write_data,
           bus.set_done, bus.busy, bus.sat_count} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got req=%b rd_wr=%b addr=%h wdata=%h done=%b busy=%b sat=%h expected all 0",
                  bus.req, bus.rd_wr, bus.user_req_addr, bus.user_write_data,
                  bus.set_done, bus.busy, bus.sat_count);
      end
      rst_n = 1'b1;
      $display("test_reset: outputs sampled under reset");
   endtask

   task automatic test_basic();
      fill_random();
      light_mem[0] = 32'h1000_0800;
      dark_mem[0]  = 32'h0100_0100;
      run_set("test_basic", 1, 1);
      n_checks++;
      if (log_addr.size() < 3 || log_addr[0] !== 21'h000000 || log_addr[1] !== 21'h040000 ||
          log_addr[2] !== 21'h080000 || log_data[2] !== 32'h0F00_0700) begin
         n_fail++;
         $display("FAIL basic_word0: got %0d reqs first write %h expected write 0f000700 at 080000",
                  log_addr.size(), (log_data.size() > 2) ? log_data[2] : 32'hX);
      end
      check_set("test_basic");
   endtask

   task automatic test_saturation();
      fill_random();
      light_mem[0] = 32'h0005_FFFF; dark_mem[0] = 32'h0010_0001;
      light_mem[1] = 32'h1234_1234; dark_mem[1] = 32'h1234_1234;
      light_mem[3] = 32'h0000_0000; dark_mem[3] = 32'hFFFF_FFFF;
      run_set("test_saturation", 1, 3);
      n_checks++;
      if (log_data.size() < 12 || log_data[2] !== 32'h0000_FFFE || log_data[5] !== 32'h0000_0000 ||
          log_data[11] !== 32'h0000_0000) begin
         n_fail++;
         $display("FAIL saturation_words: got %h %h %h expected 0000fffe 00000000 00000000",
                  (log_data.size() > 2) ? log_data[2] : 32'hX,
                  (log_data.size() > 5) ? log_data[5] : 32'hX,
                  (log_data.size() > 11) ? log_data[11] : 32'hX);
      end
      check_set("test_saturation");
   endtask

   task automatic test_random_latency();
      for (int r = 0; r < 4; r++) begin
         fill_random();
         run_set("test_random_latency", 1, 20);
         check_set("test_random_latency");
      end
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 2; r++) begin
         fill_random();
         run_set("test_back_to_back", 1, 1);
         check_set("test_back_to_back");
      end
   endtask

   task automatic test_abort();
      int cyc = 0;
      fill_random();
      start_set(6, 6);
      while (log_addr.size() < 8 && cyc < 500) begin
         @(negedge clk); #1;
         cyc++;
      end
      n_checks++;
      if (log_addr.size() != 8) begin
         n_fail++;
         $display("FAIL abort_reach_wt_d: got %0d reqs expected 8", log_addr.size());
      end
      @(negedge clk); #1;
      bus.ready_2_start = 1'b0;
      @(negedge clk); #1;
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_busy: got %b expected 0", bus.busy);
      end
      repeat (30) @(negedge clk);
      #1;
      n_checks++;
      if (log_addr.size() != 8 || done_cnt != 0) begin
         n_fail++;
         $display("FAIL abort_quiet: got %0d reqs done=%0d expected 8 reqs done=0",
                  log_addr.size(), done_cnt);
      end
      $display("test_abort: dropped in WT_D word 2, %0d requests, done=%0d", log_addr.size(), done_cnt);
   endtask

   task automatic test_reset_mid_wr();
      int cyc = 0;
      int n_before;
      fill_random();
      start_set(2, 2);
      while ((log_wr.size() == 0 || log_wr[log_wr.size()-1] !== 1'b1) && cyc < 500) begin
         @(negedge clk); #1;
         cyc++;
      end
      rst_n = 1'b0;
      @(negedge clk); #1;
      rst_n = 1'b1;
      n_checks++;
      if ({bus.req, bus.rd_wr, bus.user_req_addr, bus.user_write_data,
           bus.set_done, bus.busy, bus.sat_count} !== '0) begin
         n_fail++;
         $display("FAIL mid_wr_reset_outputs: got req=%b addr=%h wdata=%h busy=%b sat=%h expected all 0",
                  bus.req, bus.user_req_addr, bus.user_write_data, bus.busy, bus.sat_count);
      end
      n_before = log_addr.size();
      repeat (40) @(negedge clk);
      #1;
      n_checks++;
      if (log_addr.size() != n_before || bus.busy !== 1'b0 || done_cnt != 0) begin
         n_fail++;
         $display("FAIL mid_wr_no_restart: got %0d new reqs busy=%b done=%0d expected 0 0 0",
                  log_addr.size() - n_before, bus.busy, done_cnt);
      end
      $display("test_reset_mid_wr: reset during write, %0d requests before reset", n_before);
      fill_random();
      run_set("test_reset_restart", 1, 5);
      check_set("test_reset_restart");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_random_latency();
      test_back_to_back();
      test_abort();
      test_reset_mid_wr();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
